load_store_unit: RTL and testbench

Memory-access stage directly downstream of Control_Unit. Consumes MemRead/MemWrite/byte_enable/funct3 from the control unit, the ALU-computed address and the rs2 store data. Runs a valid/ready request plus read-response handshake to the data memory. Returns lane-aligned, sign- or zero-extended load data and holds a pipeline stall until the access completes.

---
 rtl/load_store_unit.sv | 214 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage sitting behind the control unit.
// Takes MemRead/MemWrite/byte_enable/funct3, the ALU address and rs2 data, and
// runs a valid/ready request plus a read-response handshake to data memory.
// Load data is lane-aligned and sign/zero-extended. Upstream stays stalled
// until the access completes.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   - misaligned half/word accesses are rejected without touching
//               memory, and misalign pulses for one cycle.
//   undefined - misalign is tied low. Misaligned accesses go to memory with
//               the upper strobe lanes dropped.
module load_store_unit #(
  parameter int bitwidth = 32  // only 32 is supported (four byte lanes)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [3:0]          byte_enable,
  input  logic [2:0]          funct3,
  input  logic [bitwidth-1:0] addr,
  input  logic [bitwidth-1:0] store_data,
  output logic                stall,
  output logic [bitwidth-1:0] load_data,
  output logic                load_valid,
  output logic                misalign,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [bitwidth-1:0] mem_addr,
  output logic [3:0]          mem_wstrb,
  output logic [bitwidth-1:0] mem_wdata,
  input  logic                mem_rvalid,
  input  logic [bitwidth-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Captured access context. Lane math is done at capture time, so the
  // memory-facing outputs come straight from flops and stay stable in REQ.
  logic                write_reg;
  logic [1:0]          shift_reg;
  logic [3:0]          be_reg;
  logic                zext_reg;
  logic [bitwidth-1:0] mem_addr_reg;
  logic [3:0]          mem_wstrb_reg;
  logic [bitwidth-1:0] mem_wdata_reg;
  logic [bitwidth-1:0] load_data_reg;
  logic                load_valid_reg;
  logic                misalign_reg;

  // Decode of the incoming request
  logic access;
  logic zero_be;
  logic trap;
  logic skip;

  assign access  = op_valid & (mem_read | mem_write);
  assign zero_be = (byte_enable == 4'b0000);

`ifdef MISALIGN_TRAP_EN
  logic is_half;
  logic is_word;
  assign is_half = (byte_enable == 4'b0011);
  assign is_word = (byte_enable == 4'b1111);
  assign trap    = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
`else
  assign trap    = 1'b0;
`endif

  // Accesses that finish without any memory traffic
  assign skip = zero_be | trap;

  // funct3[1:0] carries no information here; byte_enable already encodes the size
  logic unused_funct3;
  assign unused_funct3 = ^funct3[1:0];

  // Read-data alignment and extension, evaluated against the captured context
  logic [bitwidth-1:0] raw;
  logic [bitwidth-1:0] ext;

  assign raw = mem_rdata >> {shift_reg, 3'b000};

  // Byte and half loads take the low lanes of the shifted word; anything else is a full word
  always_comb begin
    ext = raw;
    case (be_reg)
      4'b0001: ext = zext_reg ? {{(bitwidth-8){1'b0}}, raw[7:0]}
                              : {{(bitwidth-8){raw[7]}}, raw[7:0]};
      4'b0011: ext = zext_reg ? {{(bitwidth-16){1'b0}}, raw[15:0]}
                              : {{(bitwidth-16){raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

  // State register; reset abandons any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (access) begin
          state_next = skip ? DONE : REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_next = write_reg ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // op_valid in this cycle belongs to the instruction already retired
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control outputs: stall covers the accept cycle plus every cycle spent in REQ or WAIT
  always_comb begin
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    case (state_reg)
      IDLE: stall = access;
      REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
      end
      WAIT: stall = 1'b1;
      DONE: stall = 1'b0;
      default: begin
        stall         = 1'b0;
        mem_req_valid = 1'b0;
      end
    endcase
  end

  // Datapath: capture on accept, collect read data in WAIT, pulse the completion flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_reg      <= 1'b0;
      shift_reg      <= 2'b00;
      be_reg         <= 4'b0000;
      zext_reg       <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wstrb_reg  <= 4'b0000;
      mem_wdata_reg  <= '0;
      load_data_reg  <= '0;
      load_valid_reg <= 1'b0;
      misalign_reg   <= 1'b0;
    end else begin
      load_valid_reg <= 1'b0;
      misalign_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (access) begin
            // A simultaneous read and write is handled as a write
            write_reg     <= mem_write;
            shift_reg     <= addr[1:0];
            be_reg        <= byte_enable;
            zext_reg      <= funct3[2];
            mem_addr_reg  <= {addr[bitwidth-1:2], 2'b00};
            // The 4-bit shift drops lanes that would spill past the word
            mem_wstrb_reg <= mem_write ? (byte_enable << addr[1:0]) : 4'b0000;
            mem_wdata_reg <= store_data << {addr[1:0], 3'b000};
            if (zero_be) begin
              load_data_reg <= '0;
            end
            misalign_reg  <= trap;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            load_data_reg  <= ext;
            load_valid_reg <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign load_data  = load_data_reg;
  assign load_valid = load_valid_reg;
  assign misalign   = misalign_reg;
  assign mem_we     = write_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wstrb  = mem_wstrb_reg;
  assign mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed accesses from the examples followed
// by random accesses. The bench plays the data memory, and a lane-by-lane
// reference model supplies every expected value.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  byte_enable;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_txn = 0;
  logic [31:0] last_load;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  load_store_unit #(.bitwidth(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .op_valid      (op_valid),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .byte_enable   (byte_enable),
    .funct3        (funct3),
    .addr          (addr),
    .store_data    (store_data),
    .stall         (stall),
    .load_data     (load_data),
    .load_valid    (load_valid),
    .misalign      (misalign),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wstrb     (mem_wstrb),
    .mem_wdata     (mem_wdata),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog time limit reached compared=%0d", n_cmp);
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1-2 time units after the rising edge
  task automatic cycle_begin();
    @(posedge clk);
    #1;
  endtask

  // Reference: byte lane i carries source byte (i - offset), if that byte is enabled
  function automatic logic [3:0] ref_wstrb(input logic [3:0] be, input logic [31:0] a);
    logic [3:0] s;
    int         off;
    off = int'(a % 4);
    s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (i - off >= 0) s[i] = be[i - off];
    end
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] sd, input logic [31:0] a);
    logic [31:0] w;
    int          off;
    off = int'(a % 4);
    w = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i - off >= 0) w[8*i +: 8] = sd[8*(i - off) +: 8];
    end
    return w;
  endfunction

  // Reference load value: take the addressed lanes, then sign- or zero-extend numerically
  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [3:0] be, input logic [2:0] f3);
    longint v;
    longint word;
    int     off;
    off  = int'(a % 4);
    word = longint'(rd) / (longint'(1) << (8 * off));
    if (be == 4'b0001) begin
      v = word % 256;
      if (!f3[2] && v >= 128) v = v - 256;
    end else if (be == 4'b0011) begin
      v = word % 65536;
      if (!f3[2] && v >= 32768) v = v - 65536;
    end else begin
      v = word;
    end
    return v[31:0];
  endfunction

  // One complete access. rdy_dly is the number of REQ cycles with ready low;
  // gap is the number of WAIT cycles before rvalid.
  task automatic do_access(input string name, input bit rd, input bit wr,
                           input logic [3:0] be, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rdata, input int rdy_dly, input int gap);
    bit eff_rd;
    bit mis;
    bit trapped;
    bit skip;
    eff_rd  = rd & !wr;
    mis     = (be == 4'b0011 && a[0]) || (be == 4'b1111 && a[1:0] != 2'b00);
    trapped = TRAP && mis;
    skip    = (be == 4'b0000) || trapped;

    // Accept cycle in IDLE
    cycle_begin();
    op_valid = 1'b1; mem_read = rd; mem_write = wr; byte_enable = be;
    funct3 = f3; addr = a; store_data = sd;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0;
    #1;
    check({name, ":stall_accept"}, 32'(stall), 32'd1);
    check({name, ":req_accept"}, 32'(mem_req_valid), 32'd0);

    if (skip) begin
      if (be == 4'b0000) last_load = 32'h0;
    end else begin
      for (int k = 0; k <= rdy_dly; k++) begin
        cycle_begin();
        // Scramble the stage inputs; the captured request must not move
        op_valid = 1'b0; addr = $urandom; store_data = $urandom;
        byte_enable = 4'($urandom);
        mem_req_ready = (k == rdy_dly);
        mem_rvalid = (k == rdy_dly);  // must be ignored outside WAIT
        mem_rdata = $urandom;
        #1;
        check({name, ":req_valid"}, 32'(mem_req_valid), 32'd1);
        check({name, ":req_stall"}, 32'(stall), 32'd1);
        check({name, ":mem_addr"}, mem_addr, {a[31:2], 2'b00});
        check({name, ":mem_we"}, 32'(mem_we), 32'(wr));
        check({name, ":mem_wstrb"}, 32'(mem_wstrb), wr ? 32'(ref_wstrb(be, a)) : 32'd0);
        if (wr) check({name, ":mem_wdata"}, mem_wdata, ref_wdata(sd, a));
      end
      if (eff_rd) begin
        for (int k = 0; k <= gap; k++) begin
          cycle_begin();
          mem_req_ready = 1'b0;
          mem_rvalid = (k == gap);
          mem_rdata = (k == gap) ? rdata : $urandom;
          #1;
          check({name, ":wait_stall"}, 32'(stall), 32'd1);
          check({name, ":wait_req"}, 32'(mem_req_valid), 32'd0);
        end
        last_load = ref_load(rdata, a, be, f3);
      end
    end

    // DONE cycle; a new op presented now must be ignored
    cycle_begin();
    mem_req_ready = 1'b0; mem_rvalid = 1'b0;
    op_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; byte_enable = 4'b1111;
    #1;
    check({name, ":done_stall"}, 32'(stall), 32'd0);
    check({name, ":done_req"}, 32'(mem_req_valid), 32'd0);
    check({name, ":load_valid"}, 32'(load_valid), 32'(eff_rd && !skip));
    check({name, ":misalign"}, 32'(misalign), 32'(trapped));
    check({name, ":load_data"}, load_data, last_load);

    // Back in IDLE with nothing pending; the pulses have ended
    cycle_begin();
    op_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    #1;
    check({name, ":idle_stall"}, 32'(stall), 32'd0);
    check({name, ":idle_pulse"}, 32'({load_valid, misalign}), 32'd0);

    n_txn++;
    $display("txn %0d %s rd=%0b wr=%0b be=%b f3=%b addr=%08h sd=%08h rdata=%08h load_data=%08h",
             n_txn, name, rd, wr, be, f3, a, sd, rdata, load_data);
  endtask

  initial begin
    rst = 1'b1;
    op_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; byte_enable = 4'b0;
    funct3 = 3'b0; addr = 32'h0; store_data = 32'h0;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    last_load = 32'h0;

    // Reset state
    cycle_begin();
    cycle_begin();
    #1;
    check("rst:stall", 32'(stall), 32'd0);
    check("rst:load_data", load_data, 32'd0);
    check("rst:load_valid", 32'(load_valid), 32'd0);
    check("rst:misalign", 32'(misalign), 32'd0);
    check("rst:req_valid", 32'(mem_req_valid), 32'd0);
    check("rst:mem_we", 32'(mem_we), 32'd0);
    check("rst:mem_addr", mem_addr, 32'd0);
    check("rst:mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst:mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    // Directed accesses from the examples
    do_access("SW",  1'b0, 1'b1, 4'b1111, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0);
    do_access("SB",  1'b0, 1'b1, 4'b0001, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0, 0);
    do_access("LB",  1'b1, 1'b0, 4'b0001, 3'b000, 32'h0000_0102, 32'h0, 32'h1280_7F34, 0, 0);
    do_access("LBU", 1'b1, 1'b0, 4'b0001, 3'b100, 32'h0000_0102, 32'h0, 32'h1280_7F34, 0, 0);
    do_access("LH",  1'b1, 1'b0, 4'b0011, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_FFFF, 3, 1);
    do_access("LW_mis", 1'b1, 1'b0, 4'b1111, 3'b010, 32'h0000_0101, 32'h0, 32'hA1B2_C3D4, 0, 0);
    do_access("SH_mis", 1'b0, 1'b1, 4'b0011, 3'b001, 32'h0000_0203, 32'h0000_BEEF, 32'h0, 1, 0);
    do_access("RW_both", 1'b1, 1'b1, 4'b0011, 3'b001, 32'h0000_0302, 32'h1234_5678, 32'h0, 0, 0);
    do_access("BE0", 1'b1, 1'b0, 4'b0000, 3'b010, 32'h0000_0400, 32'h0, 32'h5555_5555, 0, 0);

    // Reset in WAIT abandons the load immediately
    cycle_begin();
    op_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; byte_enable = 4'b1111;
    funct3 = 3'b010; addr = 32'h0000_0200;
    #1;
    cycle_begin();
    op_valid = 1'b0; mem_req_ready = 1'b1;
    #1;
    check("rstmid:req_valid", 32'(mem_req_valid), 32'd1);
    cycle_begin();
    mem_req_ready = 1'b0;
    #1;
    check("rstmid:wait_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid:req_valid_rst", 32'(mem_req_valid), 32'd0);
    check("rstmid:stall_rst", 32'(stall), 32'd0);
    check("rstmid:load_valid_rst", 32'(load_valid), 32'd0);
    check("rstmid:load_data_rst", load_data, 32'd0);
    #1;
    rst = 1'b0;
    last_load = 32'h0;
    // A late response for the abandoned load must be ignored
    cycle_begin();
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    check("rstmid:late_rvalid_stall", 32'(stall), 32'd0);
    cycle_begin();
    mem_rvalid = 1'b0;
    #1;
    check("rstmid:late_rvalid_lv", 32'(load_valid), 32'd0);
    do_access("LW_after_rst", 1'b1, 1'b0, 4'b1111, 3'b010, 32'h0000_0204, 32'h0, 32'hCAFE_F00D, 0, 0);

    // Random accesses
    for (int t = 0; t < 40; t++) begin
      int          ty;
      int          bi;
      logic [3:0]  be;
      bit          rd;
      bit          wr;
      ty = int'($urandom_range(0, 3));
      rd = (ty == 0) || (ty == 2) || (ty == 3);
      wr = (ty == 1) || (ty == 2);
      bi = int'($urandom_range(0, 9));
      be = (bi == 0) ? 4'b0000 : (bi < 4) ? 4'b0001 : (bi < 7) ? 4'b0011 : 4'b1111;
      do_access("RND", rd, wr, be, 3'($urandom), $urandom, $urandom, $urandom,
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
